demux_rr_dispatcher: RTL and testbench
======================================

# demux_rr_dispatcher

Sequencer for the 4-way `demux_n_4` datapath: accepts a valid/ready word stream and dispatches each word to one of four consumer channels. Destination is chosen round-robin among enabled channels, or taken from the word's destination tag. It owns the `sel` control of the demux and a one-word holding register, so a stalled consumer never corrupts the shared bus. It sits between the upstream producer and the demux/consumer fabric.

## Interface
- `BUS_WIDTH`, 8, data word width.
- `clk`  input  1  clock, rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  upstream word valid.
- `in_ready`  output  1  dispatcher can accept the word this cycle (combinational).
- `in_data`  input  BUS_WIDTH  upstream word.
- `in_dest`  input  2  destination tag; used only in directed mode.
- `mode`  input  1  0 = round-robin, 1 = directed.
- `ch_en`  input  4  per-channel enable for round-robin eligibility.
- `sel`  output  2  demux select, registered.
- `out_data`  output  BUS_WIDTH  held word, registered; drives demux `y`.
- `out_valid`  output  4  one-hot valid of held word, registered.
- `out_ready`  input  4  per-channel consumer ready.

## Operation
- Two states:
  - EMPTY: no word held; all `out_valid` = 0.
  - FULL: word held; `out_valid[sel]` = 1.
- Accept condition: `in_valid && in_ready`.
- `in_ready` = eligible && (EMPTY || (FULL && `out_ready[sel]`)).
  - eligible = `mode` || (`ch_en` != 0).
- Drain condition: FULL && `out_ready[sel]`.
- Channel choice at accept:
  - Directed mode: channel = `in_dest`; `ch_en` is ignored.
  - Round-robin mode: channel = first set `ch_en` bit scanning `rr_ptr`, `rr_ptr`+1, … mod 4.
- On accept:
  - `out_data` <= `in_data`; `sel` <= channel; `out_valid` <= one-hot(channel); state → FULL.
  - `rr_ptr` <= channel+1 mod 4, in both modes.
- On drain without accept: `out_valid` <= 0; state → EMPTY. `sel` and `out_data` hold their last values.
- Drain and accept in the same cycle: the new word replaces the old one with no bubble; state stays FULL.
- `mode`, `ch_en` and `in_dest` are sampled only at accept. Changing them while FULL does not redirect the held word.
- Clearing `ch_en` for a held word's channel does not cancel that word.

## Timing
- Reset (async assert, sync release): state EMPTY, `out_valid` = 0, `sel` = 0, `out_data` = 0, `rr_ptr` = 0.
- After reset, `in_ready` = eligible.
- Latency: word accepted at edge N appears on `out_data`/`out_valid` from edge N (visible in cycle N+1).
- Throughput: 1 word/cycle while the target consumer stays ready.
- `in_ready` depends combinationally on `out_ready`. No combinational path from `in_valid` to any output.
- Reset mid-operation: the held word is dropped and `out_valid` clears immediately (asynchronous).
- Round-robin with `ch_en` = 0: `in_ready` = 0; a held word still drains normally.
- `rr_ptr` wraps from 3 to 0.

## Configuration
- `DEMUX_RR_STATS_EN` defined:
  - Adds output `ch_count`, 64 bits, holding four 16-bit counters; channel k occupies bits [16k+15:16k].
  - Counter k increments on every drain from channel k and saturates at 16'hFFFF.
  - Counters reset to 0 on `reset_n`.
- `DEMUX_RR_STATS_EN` undefined: the port and counters are absent; all other behaviour is identical.

## Test plan
- Reset, round-robin, `ch_en`=4'b1111, all `out_ready`=1; send 8 words 0x10..0x17.
  - `sel` sequence 0,1,2,3,0,1,2,3, one word per cycle; `out_valid` one-hot matches.
- Round-robin, `ch_en`=4'b1010; send 4 words.
  - `sel` = 1,3,1,3; channels 0 and 2 never asserted.
- Directed mode, `in_dest`=2, `out_ready[2]`=0 for 5 cycles.
  - `out_valid`=4'b0100 and `out_data` stable; `in_ready`=0 throughout.
  - On `out_ready[2]`=1, drain and accept the next word in the same cycle.
- Round-robin, `ch_en`=0, `in_valid`=1.
  - `in_ready`=0; nothing accepted.
  - Set `ch_en`=4'b0100 → word goes to channel 2 next cycle.
- Assert `reset_n`=0 while FULL.
  - `out_valid`=0 and `sel`=0 immediately; after release the first round-robin word goes to channel 0.
- With `DEMUX_RR_STATS_EN`: 70000 drains on channel 0 → `ch_count[15:0]`=16'hFFFF; other counters match their drain counts.

Source files
------------

// File: rtl/demux_rr_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : demux_rr_dispatcher
// Purpose  : Sequencer for a 4-way demux datapath. Accepts a valid/ready word
//            stream, holds one word, and presents it to one of four consumer
//            channels. The channel is chosen round-robin among enabled
//            channels (mode=0) or taken from the word's tag (mode=1).
// Ports    : clk, reset_n (async active-low)
//            in_valid / in_ready / in_data / in_dest  - upstream stream
//            mode, ch_en                              - channel policy
//            sel, out_data, out_valid                 - registered demux side
//            out_ready                                - per-channel consumer ready
//            ch_count (only with DEMUX_RR_STATS_EN)   - 4 x 16-bit drain counters
// Option   : define DEMUX_RR_STATS_EN to add per-channel saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module demux_rr_dispatcher #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic [1:0]           in_dest,
  input  logic                 mode,
  input  logic [3:0]           ch_en,
  output logic [1:0]           sel,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready
`ifdef DEMUX_RR_STATS_EN
  ,
  output logic [63:0]          ch_count
`endif
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [1:0]           r_sel;
  logic [1:0]           r_rr_ptr;
  logic [BUS_WIDTH-1:0] r_data;
  logic [1:0]           w_rr_ch;
  logic [1:0]           w_ch;
  logic                 w_eligible;
  logic                 w_drain;
  logic                 w_ready;
  logic                 w_accept;

  // Directed mode is always eligible; round-robin needs at least one channel.
  assign w_eligible = mode || (ch_en != 4'b0000);
  assign w_drain    = (r_state == S_FULL) && out_ready[r_sel];
  assign w_ready    = w_eligible && ((r_state == S_EMPTY) || w_drain);
  assign w_accept   = in_valid && w_ready;

  assign in_ready   = w_ready;
  assign sel        = r_sel;
  assign out_data   = r_data;

  // First enabled channel at or after r_rr_ptr (wrapping). Scanning from the
  // farthest offset down lets the nearest enabled channel win.
  always_comb begin : p_rr_scan
    logic [1:0] v_idx;
    v_idx   = r_rr_ptr;
    w_rr_ch = r_rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      v_idx = r_rr_ptr + 2'(k);
      if (ch_en[v_idx]) begin
        w_rr_ch = v_idx;
      end
    end
  end

  assign w_ch = mode ? in_dest : w_rr_ch;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: an accept always leaves a word held, even if the old one
  // drains in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = S_FULL;
    end else if (w_drain) begin
      w_state_nxt = S_EMPTY;
    end
  end

  // Outputs: derived only from registers, so out_valid clears at once on an
  // asynchronous reset and has no path from in_valid.
  always_comb begin
    out_valid = 4'b0000;
    if (r_state == S_FULL) begin
      out_valid[r_sel] = 1'b1;
    end
  end

  // Held word, select and round-robin pointer; only touched on accept so a
  // drain leaves sel/out_data at their last values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel    <= 2'd0;
      r_data   <= '0;
      r_rr_ptr <= 2'd0;
    end else if (w_accept) begin
      r_sel    <= w_ch;
      r_data   <= in_data;
      r_rr_ptr <= w_ch + 2'd1;
    end
  end

`ifdef DEMUX_RR_STATS_EN
  logic [15:0] r_cnt [4];

  for (genvar g = 0; g < 4; g++) begin : g_stats
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt[g] <= 16'd0;
      end else if (w_drain && (r_sel == 2'(g)) && (r_cnt[g] != 16'hFFFF)) begin
        r_cnt[g] <= r_cnt[g] + 16'd1;
      end
    end
    assign ch_count[16*g +: 16] = r_cnt[g];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_rr_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_rr_dispatcher
// Purpose  : Self-checking bench for demux_rr_dispatcher: directed scenarios
//            followed by random traffic, compared against a behavioural model
//            of the held word, channel choice and round-robin pointer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_rr_dispatcher;

  localparam int BUS_WIDTH = 8;

  logic                 clk;
  logic                 reset_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [BUS_WIDTH-1:0] in_data;
  logic [1:0]           in_dest;
  logic                 mode;
  logic [3:0]           ch_en;
  logic [1:0]           sel;
  logic [BUS_WIDTH-1:0] out_data;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;
`ifdef DEMUX_RR_STATS_EN
  logic [63:0]          ch_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model
  bit                 m_held;
  int                 m_ch;
  logic [BUS_WIDTH-1:0] m_data;
  int                 m_ptr;
  int                 m_cnt [4];

  demux_rr_dispatcher #(.BUS_WIDTH(BUS_WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .mode      (mode),
    .ch_en     (ch_en),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_RR_STATS_EN
    ,
    .ch_count  (ch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_held = 1'b0;
    m_ch   = 0;
    m_data = '0;
    m_ptr  = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endfunction

  function automatic bit model_ready();
    bit elig;
    elig = mode || (ch_en != 4'b0000);
    return elig && (!m_held || out_ready[m_ch]);
  endfunction

  function automatic int model_pick();
    if (mode) return int'(in_dest);
    for (int o = 0; o < 4; o++) begin
      if (ch_en[(m_ptr + o) % 4]) return (m_ptr + o) % 4;
    end
    return 0;
  endfunction

  task automatic check_outputs(input string tag);
    logic [3:0] ev;
    ev = m_held ? (4'b0001 << m_ch) : 4'b0000;
    check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    check({tag, ".sel"},       64'(sel),       64'(m_ch));
    check({tag, ".out_data"},  64'(out_data),  64'(m_data));
  endtask

  // One clock: check in_ready against the model, take the edge, advance the
  // model with the inputs that were present at the edge, check the outputs.
  task automatic cycle(input string tag);
    bit exp_rdy, acc, drn;
    #1;
    exp_rdy = model_ready();
    check({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    acc = in_valid && exp_rdy;
    drn = m_held && out_ready[m_ch];
    @(posedge clk);
    if (drn && m_cnt[m_ch] < 65535) m_cnt[m_ch]++;
    if (acc) begin
      m_ch   = model_pick();
      m_data = in_data;
      m_held = 1'b1;
      m_ptr  = (m_ch + 1) % 4;
    end else if (drn) begin
      m_held = 1'b0;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] dest,
                       input logic md, input logic [3:0] en, input logic [3:0] rdy);
    in_valid  = v;
    in_data   = d;
    in_dest   = dest;
    mode      = md;
    ch_en     = en;
    out_ready = rdy;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111, 4'b1111);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Round-robin over all channels, consumers always ready.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(8'h10 + i), 2'd0, 1'b0, 4'b1111, 4'b1111);
      cycle("rr_all");
      check("rr_all.sel_seq", 64'(sel), 64'(i % 4));
    end
    drive(1'b0, 8'h00, 2'd0, 1'b0, 4'b1111, 4'b1111);
    cycle("rr_idle");

    // Sparse enable: only channels 1 and 3 participate.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h20 + i), 2'd0, 1'b0, 4'b1010, 4'b1111);
      cycle("rr_1010");
      check("rr_1010.sel_seq", 64'(sel), (i % 2 == 0) ? 64'd1 : 64'd3);
    end
    drive(1'b0, 8'h00, 2'd0, 1'b0, 4'b1010, 4'b1111);
    cycle("rr_1010_idle");

    // Directed to channel 2 with that consumer stalled.
    drive(1'b1, 8'hA5, 2'd2, 1'b1, 4'b0000, 4'b1011);
    cycle("dir_load");
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h5A, 2'd2, 1'b1, 4'b0000, 4'b1011);
      cycle("dir_stall");
      check("dir_stall.out_data", 64'(out_data), 64'hA5);
    end
    drive(1'b1, 8'h5A, 2'd2, 1'b1, 4'b0000, 4'b1111);
    cycle("dir_swap");
    check("dir_swap.out_data", 64'(out_data), 64'h5A);
    drive(1'b0, 8'h00, 2'd0, 1'b1, 4'b0000, 4'b1111);
    cycle("dir_idle");

    // Round-robin with nothing enabled, then enable only channel 2.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h77, 2'd0, 1'b0, 4'b0000, 4'b1111);
      cycle("rr_none");
    end
    drive(1'b1, 8'h77, 2'd0, 1'b0, 4'b0100, 4'b1111);
    cycle("rr_en2");
    check("rr_en2.out_valid", 64'(out_valid), 64'h4);

    // Asynchronous reset while a word is held.
    drive(1'b1, 8'h99, 2'd0, 1'b0, 4'b1111, 4'b0000);
    cycle("pre_reset");
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 8'h3C, 2'd0, 1'b0, 4'b1111, 4'b1111);
    cycle("post_reset");
    check("post_reset.sel", 64'(sel), 64'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0),
            8'($urandom),
            2'($urandom),
            1'($urandom_range(0, 3) == 0),
            4'($urandom),
            4'($urandom | $urandom));
      cycle("rand");
    end

`ifdef DEMUX_RR_STATS_EN
    for (int k = 0; k < 4; k++) begin
      check("stats.ch_count", 64'(ch_count[16*k +: 16]), 64'(m_cnt[k]));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
